// File: rtl/huff_axil_pkg.sv
// Shared types and constants for the Huffman AXI4-Lite register block.
package huff_axil_pkg;

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_IDX_W = 2;

  localparam logic [REG_IDX_W-1:0] REG0_IDX = 2'd0;
  localparam logic [REG_IDX_W-1:0] REG1_IDX = 2'd1;
  localparam logic [REG_IDX_W-1:0] REG2_IDX = 2'd2;
  localparam logic [REG_IDX_W-1:0] REG3_IDX = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // One-hot select of a register index, used for the per-register write pulse.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    unique case (idx)
      REG0_IDX: oh[0] = 1'b1;
      REG1_IDX: oh[1] = 1'b1;
      REG2_IDX: oh[2] = 1'b1;
      REG3_IDX: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/huff_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers for the Huffman block.
// Write and read channels run as independent FSMs; one outstanding of each.
module huff_axil_regs
  import huff_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] slv_reg_o,
  output logic [NUM_REGS-1:0]                 reg_wr_pulse_o
);

  localparam int unsigned Dw = C_S_AXI_DATA_WIDTH;
  localparam int unsigned Sw = C_S_AXI_DATA_WIDTH / 8;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [Dw-1:0]        regs_q [NUM_REGS];
  logic [Dw-1:0]        regs_d [NUM_REGS];
  logic [REG_IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [Dw-1:0]        w_data_q, w_data_d;
  logic [Sw-1:0]        w_strb_q, w_strb_d;
  logic [NUM_REGS-1:0]  pulse_q, pulse_d;
  logic [Dw-1:0]        rdata_q, rdata_d;

  logic                 aw_hs, w_hs, ar_hs;
  logic                 commit;
  logic [REG_IDX_W-1:0] cmt_idx;
  logic [Dw-1:0]        cmt_data;
  logic [Sw-1:0]        cmt_strb;
  logic [REG_IDX_W-1:0] awaddr_idx, araddr_idx;

  // Byte-offset bits and protection attributes carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign awaddr_idx = S_AXI_AWADDR[3:2];
  assign araddr_idx = S_AXI_ARADDR[3:2];

  assign S_AXI_AWREADY = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
  assign S_AXI_WREADY  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
  assign S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Write FSM: capture AW/W in any order, commit on the second handshake.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    commit     = 1'b0;
    cmt_idx    = aw_idx_q;
    cmt_data   = w_data_q;
    cmt_strb   = w_strb_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          cmt_idx    = awaddr_idx;
          cmt_data   = S_AXI_WDATA;
          cmt_strb   = S_AXI_WSTRB;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          aw_idx_d   = awaddr_idx;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d   = S_AXI_WDATA;
          w_strb_d   = S_AXI_WSTRB;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit     = 1'b1;
          cmt_data   = S_AXI_WDATA;
          cmt_strb   = S_AXI_WSTRB;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit     = 1'b1;
          cmt_idx    = awaddr_idx;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Register file next state: byte-lane merge on commit, plus the write pulse.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit) begin
      pulse_d = reg_onehot(cmt_idx);
      for (int b = 0; b < Sw; b++) begin
        if (cmt_strb[b]) regs_d[cmt_idx][8*b +: 8] = cmt_data[8*b +: 8];
      end
    end
  end

  // Read FSM: RDATA is latched from the pre-commit register value.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = regs_q[araddr_idx];
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any capture.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      regs_q     <= '{default: '0};
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      pulse_q    <= '0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      regs_q     <= regs_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      pulse_q    <= pulse_d;
      rdata_q    <= rdata_d;
    end
  end

  // Flatten registers, reg0 in the low word.
  always_comb begin
    slv_reg_o = '0;
    for (int i = 0; i < NUM_REGS; i++) slv_reg_o[i*Dw +: Dw] = regs_q[i];
  end

  assign reg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_huff_axil_regs.sv
// Randomised self-checking bench for huff_axil_regs against a register-array model.
module tb_huff_axil_regs;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESETN;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] slv_reg;
  logic [3:0]   wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_regs [4];

  always #5 tb_ACLK = ~tb_ACLK;

  huff_axil_regs dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (tb_ARESETN),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .slv_reg_o     (slv_reg),
    .reg_wr_pulse_o(wr_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-enable merge straight from the bus rules.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_word(input int idx);
    return slv_reg[idx*32 +: 32];
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_aw(input logic [3:0] addr);
    int n = 0;
    awaddr  = addr;
    awvalid = 1'b1;
    while (!awready && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) check_eq("aw_timeout", 32'(awready), 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) check_eq("w_timeout", 32'(wready), 32'd1);
    @(negedge tb_ACLK);
    wvalid = 1'b0;
  endtask

  task automatic send_both(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n = 0;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    while (!(awready && wready) && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) check_eq("aww_timeout", 32'(awready && wready), 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  // mode 0: simultaneous, 1: AW first, 2: W first. hold: cycles BREADY stays low.
  // intrude: offer a competing write to reg0 while the response is pending.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, input int hold, input bit intrude);
    int          idx;
    logic [31:0] exp_val;
    idx     = int'(addr[3:2]);
    exp_val = merge(model_regs[idx], data, strb);
    case (mode)
      1: begin
        send_aw(addr);
        repeat (gap) @(negedge tb_ACLK);
        check_eq("bvalid_early", 32'(bvalid), 32'd0);
        send_w(data, strb);
      end
      2: begin
        send_w(data, strb);
        repeat (gap) @(negedge tb_ACLK);
        check_eq("bvalid_early", 32'(bvalid), 32'd0);
        send_aw(addr);
      end
      default: send_both(addr, data, strb);
    endcase
    check_eq("bvalid", 32'(bvalid), 32'd1);
    check_eq("bresp", 32'(bresp), 32'd0);
    check_eq("wr_pulse", 32'(wr_pulse), 32'(4'b0001 << idx));
    check_eq("slv_reg_wr", slv_word(idx), exp_val);
    model_regs[idx] = exp_val;
    if (intrude) begin
      awaddr  = 4'h0;
      wdata   = 32'hFFFF_FFFF;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge tb_ACLK);
      check_eq("resp_hold", 32'({bvalid, awready, wready}), 32'b100);
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (intrude) check_eq("no_second_wr", slv_word(0), model_regs[0]);
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    check_eq("bvalid_done", 32'({bvalid, wr_pulse}), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold);
    int          n = 0;
    logic [31:0] exp_val;
    exp_val = model_regs[int'(addr[3:2])];
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) check_eq("ar_timeout", 32'(arready), 32'd1);
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    check_eq("rvalid", 32'(rvalid), 32'd1);
    check_eq("rresp", 32'(rresp), 32'd0);
    check_eq("rdata", rdata, exp_val);
    for (int h = 0; h < hold; h++) begin
      @(negedge tb_ACLK);
      check_eq("rdata_hold", rdata, exp_val);
      check_eq("rvalid_hold", 32'(rvalid), 32'd1);
    end
    rready = 1'b1;
    @(negedge tb_ACLK);
    rready = 1'b0;
    check_eq("rvalid_done", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_ARESETN = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;

    repeat (3) @(negedge tb_ACLK);
    check_eq("rst_ready", 32'({awready, wready, arready}), 32'b111);
    check_eq("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_pulse", 32'(wr_pulse), 32'd0);
    for (int i = 0; i < 4; i++) check_eq("rst_reg", slv_word(i), 32'd0);
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);

    // Directed write/read-back of all four registers.
    do_write(4'h0, 32'h0101_FFFF, 4'hF, 0, 0, 0, 1'b0);
    do_write(4'h4, 32'hABCD_0001, 4'hF, 0, 0, 0, 1'b0);
    do_write(4'h8, 32'hDEAD_0011, 4'hF, 0, 0, 0, 1'b0);
    do_write(4'hC, 32'hBEEF_0011, 4'hF, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

    // W leads AW by three cycles.
    do_write(4'h4, 32'h1234_5678, 4'hF, 2, 3, 0, 1'b0);
    check_eq("reg1_wfirst", slv_word(1), 32'h1234_5678);

    // Single byte lane onto a cleared register.
    do_write(4'h8, 32'h0000_0000, 4'hF, 0, 0, 0, 1'b0);
    do_write(4'h8, 32'hAABB_CCDD, 4'b0010, 1, 1, 0, 1'b0);
    check_eq("reg2_strb", slv_word(2), 32'h0000_CC00);

    // Zero strobe: no change, still pulses and responds.
    do_write(4'h8, 32'h5555_5555, 4'b0000, 0, 0, 0, 1'b0);

    // Back-pressure on B with a competing write offered.
    do_write(4'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 5, 1'b1);

    // Read and write commit to reg3 on the same edge.
    do_write(4'hC, 32'h1111_1111, 4'hF, 0, 0, 0, 1'b0);
    awaddr = 4'hC; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("race_valids", 32'({bvalid, rvalid}), 32'b11);
    check_eq("race_rdata", rdata, 32'h1111_1111);
    check_eq("race_reg3", slv_word(3), 32'h2222_2222);
    model_regs[3] = 32'h2222_2222;
    bready = 1'b1; rready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0; rready = 1'b0;
    do_read(4'hC, 0);

    // Reset while holding a captured AW, with W offered during reset.
    send_aw(4'h4);
    tb_ARESETN = 1'b0;
    wdata = 32'h9999_9999; wstrb = 4'hF; wvalid = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    check_eq("mid_rst_b", 32'({bvalid, wr_pulse}), 32'd0);
    wvalid = 1'b0;
    tb_ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    @(negedge tb_ACLK);
    check_eq("post_rst_b", 32'(bvalid), 32'd0);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);
    // A lone W after reset must wait for a fresh AW.
    do_write(4'h8, 32'h0F0F_0F0F, 4'hF, 2, 3, 0, 1'b0);

    // Randomised traffic.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'b0);
      end else begin
        do_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
    end
    for (int i = 0; i < 4; i++) check_eq("final_reg", slv_word(i), model_regs[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/huff_axil_regs.md
HUFF_AXIL_REGS -- requirements
Module: huff_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 registers.
REQ-003 SHALL use one clock, S_AXI_ACLK; reset is synchronous and active-low, S_AXI_ARESETN.
REQ-004 S_AXI_ACLK  in  1  clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  synchronous active-low reset.
REQ-006 S_AXI_AWADDR  in  4  write byte address.
REQ-007 S_AXI_AWPROT  in  3  ignored.
REQ-008 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write-address handshake.
REQ-009 S_AXI_WDATA  in  32  write data.
REQ-010 S_AXI_WSTRB  in  4  byte enables.
REQ-011 S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write-data handshake.
REQ-012 S_AXI_BRESP  out  2  write response, always 2'b00.
REQ-013 S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write-response handshake.
REQ-014 S_AXI_ARADDR  in  4  read byte address.
REQ-015 S_AXI_ARPROT  in  3  ignored.
REQ-016 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read-address handshake.
REQ-017 S_AXI_RDATA  out  32  read data.
REQ-018 S_AXI_RRESP  out  2  read response, always 2'b00.
REQ-019 S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read-data handshake.
REQ-020 slv_reg_o  out  128  registers 3..0 concatenated, reg0 in [31:0].
REQ-021 reg_wr_pulse_o  out  4  one-cycle pulse per register on a committed write.

Function
REQ-022 Register index SHALL be ADDR[3:2]; ADDR[1:0] ignored; every address SHALL respond OKAY.
REQ-023 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-024 AWREADY SHALL be 1 in W_IDLE and W_HAVE_W only; WREADY 1 in W_IDLE and W_HAVE_AW only.
REQ-025 AW and W SHALL be accepted in either order or simultaneously; captured address/data/strobe held until commit.
REQ-026 On the edge completing the second (or both simultaneous) handshake, the register SHALL update byte-wise per WSTRB, the matching reg_wr_pulse_o bit SHALL assert for the next cycle, and FSM SHALL enter W_RESP.
REQ-027 BVALID SHALL be 1 exactly in W_RESP (one cycle after commit) and hold until BREADY; then W_IDLE.
REQ-028 WSTRB=0 SHALL leave the register unchanged but still pulse and respond.
REQ-029 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-030 On AR handshake, RDATA SHALL latch the addressed register and RVALID assert next cycle; RDATA/RVALID stable until RREADY, then R_IDLE.
REQ-031 Read and write FSMs SHALL be independent; AR handshake on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-032 slv_reg_o SHALL reflect register contents with zero added latency after the commit edge.
REQ-033 No outstanding transactions beyond one write and one read.

Reset
REQ-034 While S_AXI_ARESETN=0 at an edge: registers 0, FSMs to idle, AWREADY/WREADY/ARREADY 1 after release, BVALID/RVALID 0, RDATA 0, reg_wr_pulse_o 0.
REQ-035 Reset mid-transaction SHALL discard captured AW/W and pending B/R without committing.

Structure
REQ-036 Shared package huff_axil_pkg SHALL hold FSM state typedefs, OKAY response constant, register-index constants.
REQ-037 Single module; no sub-module required.

Verification
REQ-038 Write 0x0101FFFF,0xABCD0001,0xDEAD0011,0xBEEF0011 to 0x0,0x4,0x8,0xC then read back -> identical data, BRESP/RRESP 00.
REQ-039 W before AW by 3 cycles, addr 0x4 data 0x12345678 -> single commit, BVALID one cycle after AW handshake, reg1=0x12345678.
REQ-040 WSTRB=4'b0010 data 0xAABBCCDD onto reg2=0x00000000 -> reg2=0x0000CC00.
REQ-041 BREADY held low 5 cycles -> BVALID stays 1, AWREADY/WREADY 0, no second write accepted.
REQ-042 Simultaneous AR and write commit on reg3 (old 0x11111111, new 0x22222222) -> RDATA=0x11111111, subsequent read 0x22222222.
REQ-043 Reset asserted in W_HAVE_AW -> no register change, no BVALID, all registers read 0.
